// File: rtl/train_pkg.sv
// Shared definitions for the train-tracking controller: state codes,
// sensor bit positions and a saturating adder used on the time path.
package train_pkg;

  localparam int TW_DEF = 19;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_S1    = 4'd1,
    ST_S2    = 4'd2,
    ST_S3    = 4'd3,
    ST_S4    = 4'd4,
    ST_S5    = 4'd5,
    ST_S6    = 4'd6,
    ST_FAULT = 4'hF
  } state_t;

  localparam int SENS_S1 = 0;
  localparam int SENS_S2 = 1;
  localparam int SENS_S3 = 2;
  localparam int SENS_S4 = 3;
  localparam int SENS_S5 = 4;
  localparam int SENS_S6 = 5;

  // a + b clamped to 2^w-1; operands are zero-extended values of width w (w <= 32)
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int w);
    logic [32:0] sum;
    logic [32:0] max_v;
    sum   = {1'b0, a} + {1'b0, b};
    max_v = (33'd1 << w) - 33'd1;
    if (sum > max_v) begin
      return max_v[31:0];
    end
    return sum[31:0];
  endfunction

endpackage

// File: rtl/train_sequencer_seg_timer.sv
// Segment elapsed-time counter: clears on request, counts while enabled,
// sticks at all-ones, and flags when the count equals the active limit.
module seg_timer
  import train_pkg::*;
#(
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [TW-1:0] limit,
  output logic [TW-1:0] elapsed,
  output logic          hit
);

  // Count up with saturation; a held (not enabled) count models the frozen fault timer
  always_ff @(posedge clk) begin
    if (rst) begin
      elapsed <= '0;
    end else if (clr) begin
      elapsed <= '0;
    end else if (en && (elapsed != '1)) begin
      elapsed <= elapsed + TW'(1);
    end
  end

  assign hit = (elapsed == limit);

endmodule

// File: rtl/train_sequencer.sv
// Central train-tracking controller: follows the train across S1..S6,
// measures each segment, supervises it against a timeout and flags faults.
//
// state    | meaning
// ST_IDLE  | waiting for S1
// ST_S1-S5 | last sensor seen was Sk, timing segment towards S(k+1)
// ST_S6    | train passed S6, holding before returning to idle
// ST_FAULT | timeout or out-of-order sensor, waiting for fault_clr
module train_sequencer
  import train_pkg::*;
#(
  parameter int TW     = TW_DEF,
  parameter int MARGIN = 1000,
  parameter int HOLD   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    sensor,
  input  logic [TW-1:0] param_time,
  input  logic          pred_valid,
  input  logic [TW-1:0] pred_time,
  input  logic          fault_clr,
  output logic [3:0]    present_state,
  output logic          meas_valid,
  output logic [TW-1:0] meas_time,
  output logic [TW-1:0] tout,
  output logic          alarm
);

  state_t        state;
  logic [TW-1:0] pred_reg;
  logic          pred_ok;
  logic [TW-1:0] elapsed;
  logic          tout_hit;

  logic          seg_state;
  logic [5:0]    exp_mask;
  logic [5:0]    own_mask;
  logic          exp_seen;
  logic          other_seen;
  logic          timeout;
  logic          bad_seq;
  logic          advance;
  logic          hold_done;
  logic          timer_clr;
  logic          timer_en;
  logic [TW-1:0] sel_time;
  logic [TW-1:0] tout_calc;
  logic [TW-1:0] meas_next;

  // Segment decode: which sensor is expected, what counts as out of order, and timer control
  always_comb begin
    seg_state  = (state >= ST_S1) && (state <= ST_S5);
    exp_mask   = 6'd1 << state[2:0];
    own_mask   = exp_mask >> 1;
    exp_seen   = |(sensor & exp_mask);
    other_seen = |(sensor & ~(exp_mask | own_mask));
    // timeout wins over a sensor arriving in the same cycle
    timeout    = seg_state && tout_hit;
    bad_seq    = seg_state && !timeout && other_seen;
    advance    = seg_state && !timeout && !other_seen && exp_seen;
    hold_done  = (state == ST_S6) && (elapsed == TW'(HOLD - 1));
    timer_clr  = (state == ST_IDLE) || advance || hold_done;
    timer_en   = seg_state || (state == ST_S6);
    sel_time   = pred_ok ? pred_reg : param_time;
    tout_calc  = TW'(sat_add(32'(sel_time), 32'(MARGIN), TW));
    meas_next  = TW'(sat_add(32'(elapsed), 32'd1, TW));
  end

  assign tout          = seg_state ? tout_calc : '0;
  assign present_state = state;

  seg_timer #(
    .TW(TW)
  ) u_seg_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .limit   (tout),
    .elapsed (elapsed),
    .hit     (tout_hit)
  );

  // Sequencing FSM with registered strobe, measurement, alarm and prediction capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      meas_valid <= 1'b0;
      meas_time  <= '0;
      alarm      <= 1'b0;
      pred_reg   <= '0;
      pred_ok    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (pred_valid) begin
        pred_reg <= pred_time;
        pred_ok  <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (sensor[SENS_S1]) begin
            state <= ST_S1;
          end
        end
        ST_S1, ST_S2, ST_S3, ST_S4, ST_S5: begin
          if (timeout || bad_seq) begin
            state <= ST_FAULT;
            alarm <= 1'b1;
          end else if (advance) begin
            state      <= state_t'(state + 4'd1);
            meas_valid <= 1'b1;
            meas_time  <= meas_next;
          end
        end
        ST_S6: begin
          if (hold_done) begin
            state <= ST_IDLE;
          end
        end
        ST_FAULT: begin
          if (fault_clr) begin
            state <= ST_IDLE;
            alarm <= 1'b0;
          end
        end
        default: begin
          state <= ST_FAULT;
          alarm <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_train_sequencer.sv
// Directed bench for train_sequencer: measurement strobes are checked by a
// scoreboard monitor, state/limit/alarm values are checked inline.
module tb_train_sequencer;

  localparam int TW     = 19;
  localparam int MARGIN = 5;
  localparam int HOLD   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    sensor;
  logic [TW-1:0] param_time;
  logic          pred_valid;
  logic [TW-1:0] pred_time;
  logic          fault_clr;
  logic [3:0]    present_state;
  logic          meas_valid;
  logic [TW-1:0] meas_time;
  logic [TW-1:0] tout;
  logic          alarm;

  logic [5:0]    sensor_s;
  logic [3:0]    present_state_s;
  logic          meas_valid_s;
  logic [7:0]    meas_time_s;
  logic [7:0]    tout_s;
  logic          alarm_s;

  int n_pass  = 0;
  int n_total = 0;
  int unsigned exp_q[$];

  train_sequencer #(.TW(TW), .MARGIN(MARGIN), .HOLD(HOLD)) dut (
    .clk           (clk),
    .rst           (rst),
    .sensor        (sensor),
    .param_time    (param_time),
    .pred_valid    (pred_valid),
    .pred_time     (pred_time),
    .fault_clr     (fault_clr),
    .present_state (present_state),
    .meas_valid    (meas_valid),
    .meas_time     (meas_time),
    .tout          (tout),
    .alarm         (alarm)
  );

  train_sequencer #(.TW(8), .MARGIN(200), .HOLD(HOLD)) dut_sat (
    .clk           (clk),
    .rst           (rst),
    .sensor        (sensor_s),
    .param_time    (8'd100),
    .pred_valid    (1'b0),
    .pred_time     (8'd0),
    .fault_clr     (1'b0),
    .present_state (present_state_s),
    .meas_valid    (meas_valid_s),
    .meas_time     (meas_time_s),
    .tout          (tout_s),
    .alarm         (alarm_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [5:0] bits);
    sensor = bits;
    @(negedge clk);
    sensor = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_fault();
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
  endtask

  // from idle, walk to state k with every segment 3 cycles long
  task automatic go_to_state(input int k);
    pulse(6'b000001);
    for (int i = 2; i <= k; i++) begin
      tick(2);
      exp_q.push_back(3);
      pulse(6'b000001 << (i - 1));
    end
  endtask

  // scoreboard monitor: every strobe must match the oldest expected measurement
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL meas_unexpected: got strobe with meas_time %0d, expected no strobe", meas_time);
      end else begin
        check("meas_time", 32'(meas_time), exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    sensor     = '0;
    sensor_s   = '0;
    param_time = TW'(20);
    pred_valid = 1'b0;
    pred_time  = '0;
    fault_clr  = 1'b0;
    tick(2);
    rst = 1'b0;

    check("rst_state", 32'(present_state), 0);
    check("rst_meas_valid", 32'(meas_valid), 0);
    check("rst_meas_time", 32'(meas_time), 0);
    check("rst_tout", 32'(tout), 0);
    check("rst_alarm", 32'(alarm), 0);

    // full run, segments of 10 cycles, limit 20+5
    pulse(6'b000001);
    check("run_state1", 32'(present_state), 1);
    check("run_tout", 32'(tout), 25);
    for (int k = 2; k <= 6; k++) begin
      tick(9);
      exp_q.push_back(10);
      pulse(6'b000001 << (k - 1));
      check("run_state", 32'(present_state), 32'(k));
    end
    check("s6_tout", 32'(tout), 0);
    tick(3);
    check("hold_last", 32'(present_state), 6);
    tick(1);
    check("hold_done", 32'(present_state), 0);
    check("run_alarm", 32'(alarm), 0);

    // boundary: distance 25 accepted, 26 times out
    pulse(6'b000001);
    tick(24);
    exp_q.push_back(25);
    pulse(6'b000010);
    check("dist25_state", 32'(present_state), 2);
    do_reset();
    pulse(6'b000001);
    tick(25);
    check("dist26_pre", 32'(present_state), 1);
    check("dist26_tout", 32'(tout), 25);
    pulse(6'b000010);
    check("dist26_state", 32'(present_state), 32'hF);
    check("dist26_alarm", 32'(alarm), 1);

    // fault ignores sensors, clears only on fault_clr
    sensor = 6'h3F;
    tick(3);
    sensor = '0;
    check("fault_hold", 32'(present_state), 32'hF);
    clear_fault();
    check("fclr_state", 32'(present_state), 0);
    check("fclr_alarm", 32'(alarm), 0);
    pulse(6'b000001);
    check("fclr_s1", 32'(present_state), 1);
    do_reset();

    // late prediction raises the limit mid-segment
    pulse(6'b000001);
    tick(9);
    exp_q.push_back(10);
    pulse(6'b000010);
    check("pred_state2", 32'(present_state), 2);
    tick(3);
    pred_valid = 1'b1;
    pred_time  = TW'(100);
    check("pred_tout_before", 32'(tout), 25);
    tick(1);
    pred_valid = 1'b0;
    check("pred_tout_after", 32'(tout), 105);
    tick(85);
    exp_q.push_back(90);
    pulse(6'b000100);
    check("pred_dist90", 32'(present_state), 3);

    // out-of-order handling
    pulse(6'b000100);
    check("own_ignored", 32'(present_state), 3);
    pulse(6'b010000);
    check("s5_in_3", 32'(present_state), 32'hF);
    clear_fault();
    go_to_state(3);
    check("reach3", 32'(present_state), 3);
    pulse(6'b011000);
    check("s4s5_in_3", 32'(present_state), 32'hF);
    clear_fault();
    pulse(6'b001000);
    check("idle_s4", 32'(present_state), 0);

    // reset mid-segment clears everything including the prediction
    go_to_state(4);
    tick(7);
    check("pred_persists", 32'(tout), 105);
    do_reset();
    check("mid_rst_state", 32'(present_state), 0);
    check("mid_rst_meas_valid", 32'(meas_valid), 0);
    check("mid_rst_meas_time", 32'(meas_time), 0);
    check("mid_rst_tout", 32'(tout), 0);
    check("mid_rst_alarm", 32'(alarm), 0);
    pulse(6'b000001);
    check("post_rst_tout", 32'(tout), 25);
    do_reset();

    // saturating limit on the narrow instance
    check("sat_idle_tout", 32'(tout_s), 0);
    sensor_s = 6'b000001;
    @(negedge clk);
    sensor_s = '0;
    check("sat_state", 32'(present_state_s), 1);
    check("sat_tout", 32'(tout_s), 255);

    tick(3);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/train_sequencer.md
Name: train_sequencer

Overview:
- Central controller for the six-sensor train-tracking datapath.
- Tracks the train through sensors S1..S6 in order and measures the sensor-to-sensor transit time of each segment.
- Hands each measurement to the predictor and supervises each segment against a timeout built from the predicted or parameter time.
- Drives the present-state code consumed by the display, and raises an alarm on timeout or an out-of-order sensor.

Parameters:
- TW, 19: width of the time/counter path.
- MARGIN, 1000: cycles added to the selected segment time to form the timeout limit. Must be ≥1.
- HOLD, 4: cycles state 6 is held after S6 before returning to idle.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sensor  in  6  already-synchronized single-cycle sensor pulses; bit k-1 = Sk
- param_time  in  TW  nominal segment time for the current state, from the parameters block
- pred_valid  in  1  one-cycle strobe; pred_time is valid
- pred_time  in  TW  predicted segment time
- fault_clr  in  1  operator clear of the alarm
- present_state  out  4  0 = idle, 1..6 = last sensor seen, 4'hF = fault
- meas_valid  out  1  one-cycle strobe; meas_time is valid
- meas_time  out  TW  measured sensor-to-sensor distance in cycles
- tout  out  TW  active timeout limit
- alarm  out  1  high while in fault

Behaviour:
- Reset (rst sampled high on a clk edge):
  - present_state=0, meas_valid=0, meas_time=0, tout=0, alarm=0.
  - Elapsed counter=0, pred_reg=0, pred_ok=0.
  - Reset mid-segment aborts immediately; it has priority over every other event.
- Idle (0):
  - Only sensor[0] is acted on; all other bits are ignored.
  - S1 → state 1 on the next edge.
- Segment states k=1..5:
  - The elapsed counter is 0 in the first cycle of the state, increments each cycle, and saturates at 2^TW-1.
  - Expected sensor is S(k+1).
  - Sk re-asserting is ignored.
  - Any other bit set (including alongside the expected one) → fault.
  - On the expected sensor: state k+1; meas_valid=1 for exactly one cycle (the cycle after the sensor edge); meas_time=elapsed+1, saturating.
  - Example: S1 in cycle t, S2 in cycle t+10 → meas_time=10.
- Timeout limit:
  - tout = (pred_ok ? pred_reg : param_time) + MARGIN, saturating at 2^TW-1.
  - Recomputed combinationally every cycle, so a late prediction takes effect mid-segment.
  - In states 0, 6 and F, tout=0.
  - Timeout fires when elapsed == tout with no valid expected sensor → fault.
  - Timeout has priority over a sensor arriving in the same cycle. The maximum accepted distance is therefore tout.
- State 6:
  - Entered on S6.
  - Sensors are ignored for HOLD cycles, then the block returns to 0.
- Prediction capture:
  - On any pred_valid (all states except during reset), pred_reg ← pred_time and pred_ok ← 1.
  - Predictions persist across trains; only rst clears pred_ok.
  - pred_time=0 is a legal prediction.
- Fault (4'hF):
  - alarm=1, the elapsed counter is frozen, and sensors are ignored.
  - fault_clr → state 0 and alarm=0 on the next edge.
  - fault_clr in any other state has no effect.
- The meas_valid strobe is never asserted in 0, 6→0, or F transitions. Only 1→2 .. 5→6 generate a strobe.

Decomposition:
- Shared package train_pkg:
  - TW default.
  - State constants ST_IDLE=4'd0 and ST_FAULT=4'hF.
  - Sensor index constants.
  - Saturating-add helper function.
- Sub-module seg_timer:
  - Elapsed counter with clear, saturation and the elapsed==limit compare.
  - Instantiated once.
  - The FSM, prediction register and limit mux stay in train_sequencer.

Test Plan:
- Reset, then S1..S6 spaced 10 cycles, param_time=20, MARGIN=5 → states 1..6; five meas_valid strobes each with meas_time=10; HOLD=4 cycles in state 6, then 0; alarm never set.
- param_time=20, MARGIN=5, no prediction; S1, then S2 at distance 25 → accepted with meas_time=25. Repeat with S2 at distance 26 → state F and alarm=1 at the elapsed==25 edge; no meas_valid.
- In state 2, pred_valid with pred_time=100 at elapsed=3 → tout changes from param_time+MARGIN to 100+MARGIN the next cycle; S3 at distance 90 is accepted.
- In state 3, pulse S5 alone → fault. pulse S4|S5 together → fault. pulse S3 → ignored, state stays 3. In idle, pulse S4 → stays 0.
- Enter fault, hold sensors active → stays F. fault_clr=1 → state 0, alarm=0 next edge. S1 → state 1.
- Assert rst in state 4 at elapsed=7 → next edge all outputs 0 and pred_ok=0. A following run uses param_time for tout.
- Saturation check with TW=8, MARGIN=200, param_time=100 → tout=255.
